// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the brisc execute sequencer: opcodes, FSM states,
// instruction field layout and I-type immediate sign extension.
package brisc_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;

    typedef enum logic [2:0] {
        IDLE,
        RS1,
        RS2,
        EXEC,
        WB
    } seq_state_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_instr_t;

    // Sign-extend a 12-bit I-type immediate to 32 bits
    function automatic logic [31:0] imm_i(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer for RV32 OP / OP-IMM instructions.
// Reads operands through a single combinational register-file port, drives
// the shared ALU, then writes the latched result back to rd.
// Optional build macro: ALU_EXEC_SEQ_PERF_EN adds a retired-instruction counter.
module alu_exec_seq
    import brisc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [RADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]    rf_rdata,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [2:0]         alu_funct3,
    output logic [6:0]         alu_funct7,
    input  logic [XLEN-1:0]    alu_out,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               busy,
    output logic               illegal
`ifdef ALU_EXEC_SEQ_PERF_EN
    ,
    output logic [31:0]        retired_cnt
`endif
);

    seq_state_t      state;
    seq_state_t      next_state;
    rv_instr_t       instr_q;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] result;
    logic            illegal_q;
    logic            accept;
    logic            legal;

    assign accept  = instr_valid && ((state == IDLE) || (state == WB));
    assign legal   = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM);
    assign busy    = (state != IDLE);
    assign illegal = illegal_q;

    // State register plus operand/result capture for the active phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            instr_q   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            illegal_q <= accept && !legal;
            if (accept) begin
                instr_q <= rv_instr_t'(instr);
                if (instr[6:0] == OPC_OP_IMM) begin
                    op_b <= XLEN'(signed'(imm_i(instr[31:20])));
                end
            end
            case (state)
                RS1:     op_a   <= rf_rdata;
                RS2:     op_b   <= rf_rdata;
                EXEC:    result <= alu_out;
                default: ;
            endcase
        end
    end

    // Next-state and per-state output decode; everything idles at zero
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        rf_raddr    = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_funct3  = '0;
        alu_funct7  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
            end
            RS1: begin
                rf_raddr   = RADDR_W'(instr_q.rs1);
                next_state = (instr_q.opcode == OPC_OP) ? RS2 : EXEC;
            end
            RS2: begin
                rf_raddr   = RADDR_W'(instr_q.rs2);
                next_state = EXEC;
            end
            EXEC: begin
                alu_a      = op_a;
                alu_b      = op_b;
                alu_funct3 = instr_q.funct3;
                // OP-IMM only carries funct7 for shifts; elsewhere those bits are immediate
                if ((instr_q.opcode == OPC_OP) || (instr_q.funct3 == 3'h5)) begin
                    alu_funct7 = instr_q.funct7;
                end
                next_state = WB;
            end
            WB: begin
                instr_ready = 1'b1;
                rf_we       = (instr_q.rd != 5'd0);
                rf_waddr    = RADDR_W'(instr_q.rd);
                rf_wdata    = result;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (accept) begin
            next_state = legal ? RS1 : IDLE;
        end
    end

`ifdef ALU_EXEC_SEQ_PERF_EN
    // Count every completed write-back phase, including writes to x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (state == WB) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq with a behavioural register
// file and ALU attached. Honours ALU_EXEC_SEQ_PERF_EN when defined.
module tb_alu_exec_seq;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_out;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        illegal;
`ifdef ALU_EXEC_SEQ_PERF_EN
    logic [31:0] retired_cnt;
`endif

    logic [31:0] rf [32];
    int checks;
    int failures;

    alu_exec_seq #(.XLEN(32), .RADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_funct3  (alu_funct3),
        .alu_funct7  (alu_funct7),
        .alu_out     (alu_out),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .illegal     (illegal)
`ifdef ALU_EXEC_SEQ_PERF_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, x0 hard-wired, synchronous write
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : rf[rf_raddr];
    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // Small ALU covering the operations used below
    always_comb begin
        alu_out = 32'd0;
        case (alu_funct3)
            3'h0:    alu_out = alu_funct7[5] ? (alu_a - alu_b) : (alu_a + alu_b);
            3'h1:    alu_out = alu_a << alu_b[4:0];
            3'h5:    alu_out = alu_funct7[5] ? 32'($signed(alu_a) >>> alu_b[4:0]) : (alu_a >> alu_b[4:0]);
            3'h7:    alu_out = alu_a & alu_b;
            default: alu_out = alu_a | alu_b;
        endcase
    end

    task automatic applyStimulus(input logic valid, input logic [31:0] word);
        instr_valid = valid;
        instr       = word;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0);

        // Reset state
        #2;
        checkOutput("rst_ready", 32'(instr_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_we", 32'(rf_we), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_raddr", 32'(rf_raddr), 32'd0);
        step();
        rst_n = 1'b1;

        // add x3,x1,x2
        step();
        applyStimulus(1'b1, 32'h002081B3);
        step();
        applyStimulus(1'b0, 32'h0);
        checkOutput("add_rs1_raddr", 32'(rf_raddr), 32'd1);
        checkOutput("add_busy", 32'(busy), 32'd1);
        checkOutput("add_rs1_ready", 32'(instr_ready), 32'd0);
        step();
        checkOutput("add_rs2_raddr", 32'(rf_raddr), 32'd2);
        step();
        checkOutput("add_exec_a", alu_a, 32'd5);
        checkOutput("add_exec_b", alu_b, 32'd7);
        checkOutput("add_exec_f3", 32'(alu_funct3), 32'd0);
        checkOutput("add_exec_f7", 32'(alu_funct7), 32'd0);
        checkOutput("add_exec_we", 32'(rf_we), 32'd0);
        checkOutput("add_exec_raddr", 32'(rf_raddr), 32'd0);
        step();
        checkOutput("add_wb_we", 32'(rf_we), 32'd1);
        checkOutput("add_wb_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("add_wb_wdata", rf_wdata, 32'd12);
        checkOutput("add_wb_ready", 32'(instr_ready), 32'd1);
        step();
        checkOutput("add_idle_we", 32'(rf_we), 32'd0);
        checkOutput("add_idle_busy", 32'(busy), 32'd0);

        // sub x3,x1,x2
        applyStimulus(1'b1, 32'h402081B3);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        step();
        checkOutput("sub_exec_f7", 32'(alu_funct7), 32'h20);
        step();
        checkOutput("sub_wb_we", 32'(rf_we), 32'd1);
        checkOutput("sub_wb_wdata", rf_wdata, 32'hFFFFFFFE);
        step();

        // addi x5,x0,-1
        applyStimulus(1'b1, 32'hFFF00293);
        step();
        applyStimulus(1'b0, 32'h0);
        checkOutput("addi_rs1_raddr", 32'(rf_raddr), 32'd0);
        step();
        checkOutput("addi_exec_a", alu_a, 32'd0);
        checkOutput("addi_exec_b", alu_b, 32'hFFFFFFFF);
        checkOutput("addi_exec_f7", 32'(alu_funct7), 32'd0);
        step();
        checkOutput("addi_wb_we", 32'(rf_we), 32'd1);
        checkOutput("addi_wb_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("addi_wb_wdata", rf_wdata, 32'hFFFFFFFF);
        step();

        // srai x6,x1,1: shift keeps funct7 on OP-IMM
        applyStimulus(1'b1, 32'h4010D313);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        checkOutput("srai_exec_b", alu_b, 32'h00000401);
        checkOutput("srai_exec_f3", 32'(alu_funct3), 32'd5);
        checkOutput("srai_exec_f7", 32'(alu_funct7), 32'h20);
        step();
        checkOutput("srai_wb_waddr", 32'(rf_waddr), 32'd6);
        checkOutput("srai_wb_wdata", rf_wdata, 32'd2);
        step();

        // add x0,x1,x2 then add x3,x1,x2 issued in the first one's WB
        applyStimulus(1'b1, 32'h00208033);
        step();
        applyStimulus(1'b1, 32'h002081B3);
        checkOutput("b2b_rs1_raddr", 32'(rf_raddr), 32'd1);
        step();
        step();
        checkOutput("b2b_exec_we", 32'(rf_we), 32'd0);
        step();
        checkOutput("b2b_x0_we", 32'(rf_we), 32'd0);
        checkOutput("b2b_x0_ready", 32'(instr_ready), 32'd1);
        step();
        applyStimulus(1'b0, 32'h0);
        checkOutput("b2b_second_rs1", 32'(rf_raddr), 32'd1);
        checkOutput("b2b_second_busy", 32'(busy), 32'd1);
        step();
        checkOutput("b2b_second_rs2", 32'(rf_raddr), 32'd2);
        step();
        checkOutput("b2b_second_exec_we", 32'(rf_we), 32'd0);
        step();
        checkOutput("b2b_second_we", 32'(rf_we), 32'd1);
        checkOutput("b2b_second_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("b2b_second_wdata", rf_wdata, 32'd12);
        step();

        // Illegal opcode
        applyStimulus(1'b1, 32'h00000000);
        checkOutput("ill_before", 32'(illegal), 32'd0);
        step();
        applyStimulus(1'b0, 32'h0);
        checkOutput("ill_pulse", 32'(illegal), 32'd1);
        checkOutput("ill_busy", 32'(busy), 32'd0);
        checkOutput("ill_we", 32'(rf_we), 32'd0);
        checkOutput("ill_ready", 32'(instr_ready), 32'd1);
        step();
        checkOutput("ill_after", 32'(illegal), 32'd0);
        checkOutput("ill_after_busy", 32'(busy), 32'd0);

        // Reset during EXEC of an add
        applyStimulus(1'b1, 32'h002081B3);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        step();
        checkOutput("mid_exec_a", alu_a, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 32'(instr_ready), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_alu_a", alu_a, 32'd0);
        checkOutput("mid_rst_alu_b", alu_b, 32'd0);
        checkOutput("mid_rst_f3", 32'(alu_funct3), 32'd0);
        checkOutput("mid_rst_we", 32'(rf_we), 32'd0);
        step();
        checkOutput("mid_rst_we_hold", 32'(rf_we), 32'd0);
`ifdef ALU_EXEC_SEQ_PERF_EN
        checkOutput("perf_after_rst", retired_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Add after reset completes normally
        applyStimulus(1'b1, 32'h002081B3);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        step();
        step();
        checkOutput("post_rst_we", 32'(rf_we), 32'd1);
        checkOutput("post_rst_wdata", rf_wdata, 32'd12);
        step();
        checkOutput("post_rst_idle", 32'(busy), 32'd0);
`ifdef ALU_EXEC_SEQ_PERF_EN
        checkOutput("perf_after_add", retired_cnt, 32'd1);
`endif

        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Multi-cycle execute sequencer for the brisc core.
- Accepts one 32-bit RV32 OP / OP-IMM instruction over a valid/ready handshake.
- Reads rs1 and rs2 through the register file's single combinational read port and drives the shared combinational ALU (operands, funct3, funct7).
- Latches the ALU result and writes it back to rd.

Parameters:
- XLEN, 32, datapath width; the ALU and register file data are XLEN wide.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  32  instruction word.
- rf_raddr  out  RADDR_W  register file read address.
- rf_rdata  in  XLEN  read data, combinational from rf_raddr in the same cycle.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_funct3  out  3  ALU funct3.
- alu_funct7  out  7  ALU funct7.
- alu_out  in  XLEN  ALU result, combinational.
- rf_we  out  1  write-back enable.
- rf_waddr  out  RADDR_W  write-back address.
- rf_wdata  out  XLEN  write-back data.
- busy  out  1  high in every state except IDLE.
- illegal  out  1  one-cycle pulse when an unsupported opcode is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All internal registers clear.
  - All outputs are 0 except instr_ready=1.
  - Asserting reset mid-instruction abandons it with no write-back.
- States: IDLE, RS1, RS2, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch instr.
  - Opcode 7'h33 (OP) or 7'h13 (OP-IMM): go to RS1.
  - Any other opcode: stay in IDLE and pulse illegal for one cycle; no register file or ALU activity follows.
- RS1: rf_raddr=rs1 (instr[19:15]); capture rf_rdata into opA. Next state is RS2 for OP, EXEC for OP-IMM.
- RS2: rf_raddr=rs2 (instr[24:20]); capture rf_rdata into opB. Next state is EXEC.
- OP-IMM operand B: opB = sign-extended instr[31:20], loaded at accept.
- EXEC:
  - alu_a=opA, alu_b=opB, alu_funct3=instr[14:12].
  - alu_funct7=instr[31:25] for OP.
  - For OP-IMM, alu_funct7=instr[31:25] only when funct3=3'h5, otherwise 7'h00. This keeps ADDI with a negative immediate from selecting subtract.
  - Capture alu_out into the result register. Next state is WB.
- WB:
  - rf_we=1 unless rd (instr[11:7])==0; rd=x0 suppresses the write.
  - rf_waddr=rd, rf_wdata=result.
  - instr_ready=1 in WB as well.
  - On handshake, go directly to RS1 (or back to IDLE with an illegal pulse if the opcode is unsupported); otherwise go to IDLE.
- Outside their active states, alu_a, alu_b, alu_funct3, alu_funct7 and rf_raddr are held at 0.
- Latency, counted from the accept edge to the rf_we cycle:
  - OP: 4 cycles.
  - OP-IMM: 3 cycles.
- Throughput with back-to-back valid:
  - OP: one per 4 cycles.
  - OP-IMM: one per 3 cycles.
- Register file write is synchronous, so an instruction accepted in WB reads its operands in RS1 after the write has landed. No bypass is needed.
- Arithmetic is mod 2^XLEN and performed by the ALU; the sequencer does no arithmetic.
- instr is sampled only on handshake, so changes while busy are ignored.

Optional Feature:
- Macro: ALU_EXEC_SEQ_PERF_EN.
- Defined:
  - Adds output retired_cnt [31:0].
  - Increments by 1 in each WB cycle, including rd=x0, excluding illegal instructions.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package brisc_pkg holds:
  - Opcode constants OPC_OP=7'h33 and OPC_OP_IMM=7'h13.
  - State enum seq_state_t.
  - Packed instruction-field typedef rv_instr_t (funct7, rs2, rs1, funct3, rd, opcode).
  - Function imm_i() for sign extension.
- No sub-module; a single FSM module is natural.

Test Plan:
- Add, positive operands: x1=5, x2=7, instr 0x002081B3 (add x3,x1,x2).
  - rf_raddr=1 then 2.
  - EXEC shows funct3=0, funct7=0.
  - rf_we with waddr=3, wdata=12, exactly 4 cycles after accept.
- Subtract: x1=5, x2=7, instr 0x402081B3 (sub x3,x1,x2) -> funct7=7'h20 in EXEC; wdata=0xFFFFFFFE.
- Negative immediate: instr 0xFFF00293 (addi x5,x0,-1) -> alu_b=0xFFFFFFFF, funct7=0; waddr=5, wdata=0xFFFFFFFF, 3 cycles after accept.
- Write to x0 with back-to-back issue: instr 0x00208033 (add x0,x1,x2), held valid, followed by 0x002081B3.
  - No rf_we for the first instruction.
  - The second is accepted in the first's WB cycle; its rf_we comes 4 cycles later.
- Illegal opcode: instr 0x00000000 -> illegal=1 for one cycle; busy stays 0, rf_we stays 0, instr_ready stays 1.
- Reset mid-operation: assert rst_n=0 during EXEC of an add.
  - All outputs go to 0 immediately with instr_ready=1; no rf_we.
  - With ALU_EXEC_SEQ_PERF_EN, retired_cnt=0 after reset and counts 1 after the next completed add.
